// File: rtl/axi_lite_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_slave_regfile
// Brief    : AXI4-lite slave register bank; register 0 is a read-only ID,
//            the remaining registers are read/write.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_slave_regfile #(
    parameter int                   DATA_SIZE = 32,
    parameter int                   ADDR_SIZE = 32,
    parameter int                   NUM_REGS  = 16,
    parameter logic [DATA_SIZE-1:0] ID_VALUE  = 32'hA11E_0001
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 awvalid,
    output logic                 awready,
    input  logic [ADDR_SIZE-1:0] awaddr,
    input  logic                 awid,
    input  logic                 wvalid,
    output logic                 wready,
    input  logic [DATA_SIZE-1:0] wdata,
    input  logic                 wlast,
    output logic                 bvalid,
    input  logic                 bready,
    output logic                 bresp,
    output logic                 bid,
    input  logic                 arvalid,
    output logic                 arready,
    input  logic [ADDR_SIZE-1:0] araddr,
    input  logic                 arid,
    output logic                 rvalid,
    input  logic                 rready,
    output logic [DATA_SIZE-1:0] rdata,
    output logic                 rresp,
    output logic                 rid,
    output logic                 rlast
);

    localparam int c_idx_w = $clog2(NUM_REGS);

    localparam logic [1:0] c_w_idle      = 2'd0;
    localparam logic [1:0] c_w_addr_held = 2'd1;
    localparam logic [1:0] c_w_data_held = 2'd2;
    localparam logic [1:0] c_w_resp      = 2'd3;

    localparam logic c_r_idle = 1'b0;
    localparam logic c_r_resp = 1'b1;

    // Every AXI-lite beat is the last one, so wlast carries no information.
    logic w_unused_wlast;
    assign w_unused_wlast = wlast;

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    logic [1:0]           r_w_state;
    logic [1:0]           w_w_state_nxt;
    logic                 w_commit;
    logic [ADDR_SIZE-1:0] r_awaddr;
    logic                 r_awid;
    logic [DATA_SIZE-1:0] r_wdata;
    logic                 r_bresp;
    logic                 r_bid;

    logic [ADDR_SIZE-1:0] w_c_addr;
    logic [DATA_SIZE-1:0] w_c_data;
    logic                 w_c_id;
    logic [c_idx_w-1:0]   w_c_idx;
    logic                 w_c_oor;
    logic                 w_c_err;

    // The half of the transaction that arrived first comes from the holding
    // registers; the other half is taken live from the bus.
    assign w_c_addr = (r_w_state == c_w_addr_held) ? r_awaddr : awaddr;
    assign w_c_id   = (r_w_state == c_w_addr_held) ? r_awid   : awid;
    assign w_c_data = (r_w_state == c_w_data_held) ? r_wdata  : wdata;
    assign w_c_idx  = w_c_addr[c_idx_w+1:2];
    assign w_c_oor  = |(w_c_addr >> (c_idx_w + 2));
    assign w_c_err  = w_c_oor || (w_c_idx == '0);

    always_comb begin
        w_w_state_nxt = r_w_state;
        w_commit      = 1'b0;
        case (r_w_state)
            c_w_idle: begin
                if (awvalid && wvalid) begin
                    w_commit      = 1'b1;
                    w_w_state_nxt = c_w_resp;
                end else if (awvalid) begin
                    w_w_state_nxt = c_w_addr_held;
                end else if (wvalid) begin
                    w_w_state_nxt = c_w_data_held;
                end
            end
            c_w_addr_held: begin
                if (wvalid) begin
                    w_commit      = 1'b1;
                    w_w_state_nxt = c_w_resp;
                end
            end
            c_w_data_held: begin
                if (awvalid) begin
                    w_commit      = 1'b1;
                    w_w_state_nxt = c_w_resp;
                end
            end
            c_w_resp: begin
                if (bready) begin
                    w_w_state_nxt = c_w_idle;
                end
            end
            default: w_w_state_nxt = c_w_idle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_w_state <= c_w_idle;
            r_awaddr  <= '0;
            r_awid    <= 1'b0;
            r_wdata   <= '0;
            r_bresp   <= 1'b0;
            r_bid     <= 1'b0;
        end else begin
            r_w_state <= w_w_state_nxt;
            if ((r_w_state == c_w_idle) && awvalid && !wvalid) begin
                r_awaddr <= awaddr;
                r_awid   <= awid;
            end
            if ((r_w_state == c_w_idle) && wvalid && !awvalid) begin
                r_wdata <= wdata;
            end
            if (w_commit) begin
                r_bresp <= w_c_err;
                r_bid   <= w_c_id;
            end
        end
    end

    // Readies are forced low while reset is held so every output reads 0.
    assign awready = !reset && ((r_w_state == c_w_idle) || (r_w_state == c_w_data_held));
    assign wready  = !reset && ((r_w_state == c_w_idle) || (r_w_state == c_w_addr_held));
    assign bvalid  = (r_w_state == c_w_resp);
    assign bresp   = r_bresp;
    assign bid     = r_bid;

    // ------------------------------------------------------------------
    // Register storage; index 0 is the hard-wired ID
    // ------------------------------------------------------------------
    logic [DATA_SIZE-1:0] w_view [NUM_REGS];

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        if (gi == 0) begin : g_id
            assign w_view[gi] = ID_VALUE;
        end else begin : g_rw
            logic [DATA_SIZE-1:0] r_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_q <= '0;
                end else if (w_commit && !w_c_err && (w_c_idx == c_idx_w'(gi))) begin
                    r_q <= w_c_data;
                end
            end
            assign w_view[gi] = r_q;
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    logic                 r_r_state;
    logic                 w_r_state_nxt;
    logic                 w_ar_take;
    logic [c_idx_w-1:0]   w_ar_idx;
    logic                 w_ar_oor;
    logic [DATA_SIZE-1:0] r_rdata;
    logic                 r_rresp;
    logic                 r_rid;

    assign w_ar_idx = araddr[c_idx_w+1:2];
    assign w_ar_oor = |(araddr >> (c_idx_w + 2));

    always_comb begin
        w_r_state_nxt = r_r_state;
        w_ar_take     = 1'b0;
        case (r_r_state)
            c_r_idle: begin
                if (arvalid) begin
                    w_ar_take     = 1'b1;
                    w_r_state_nxt = c_r_resp;
                end
            end
            c_r_resp: begin
                if (rready) begin
                    w_r_state_nxt = c_r_idle;
                end
            end
            default: w_r_state_nxt = c_r_idle;
        endcase
    end

    // Sampling w_view at the commit edge returns the pre-write value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_r_state <= c_r_idle;
            r_rdata   <= '0;
            r_rresp   <= 1'b0;
            r_rid     <= 1'b0;
        end else begin
            r_r_state <= w_r_state_nxt;
            if (w_ar_take) begin
                r_rdata <= w_ar_oor ? '0 : w_view[w_ar_idx];
                r_rresp <= w_ar_oor;
                r_rid   <= arid;
            end
        end
    end

    assign arready = !reset && (r_r_state == c_r_idle);
    assign rvalid  = (r_r_state == c_r_resp);
    assign rlast   = rvalid;
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;
    assign rid     = r_rid;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_slave_regfile
// Brief    : Directed self-checking bench for axi_lite_slave_regfile.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_slave_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        awvalid, awready, awid;
    logic [31:0] awaddr;
    logic        wvalid, wready, wlast;
    logic [31:0] wdata;
    logic        bvalid, bready, bresp, bid;
    logic        arvalid, arready, arid;
    logic [31:0] araddr;
    logic        rvalid, rready, rresp, rid, rlast;
    logic [31:0] rdata;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    axi_lite_slave_regfile dut (
        .clk(clk), .reset(reset),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .rid(rid), .rlast(rlast)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Same-cycle aw+w write; returns response seen one cycle after handshake.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic id,
                            output logic v, output logic resp, output logic b_id);
        awvalid = 1'b1; wvalid = 1'b1; awaddr = a; wdata = d; awid = id; wlast = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
        v = bvalid; resp = bresp; b_id = bid;
        bready = 1'b1;
        step();
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic id,
                           output logic v, output logic [31:0] d, output logic resp,
                           output logic r_id, output logic last);
        arvalid = 1'b1; araddr = a; arid = id;
        step();
        arvalid = 1'b0;
        v = rvalid; d = rdata; resp = rresp; r_id = rid; last = rlast;
        rready = 1'b1;
        step();
        rready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        tests++; if ({awready, wready, bvalid, bresp, bid, arready, rvalid, rresp, rid, rlast} !== 10'b0)
            begin fails++; $display("FAIL reset_ctrl_outs: got %b expected 0", {awready, wready, bvalid, bresp, bid, arready, rvalid, rresp, rid, rlast}); end
        tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        step(); step();
        reset = 1'b0;
        #1;
        tests++; if ({awready, wready, arready} !== 3'b111)
            begin fails++; $display("FAIL post_reset_ready: got %b expected 111", {awready, wready, arready}); end
    endtask

    task automatic test_write_same_cycle();
        logic v, r, i, l; logic [31:0] d;
        do_write(32'h04, 32'hDEADBEEF, 1'b1, v, r, i);
        tests++; if ({v, r, i} !== 3'b101) begin fails++; $display("FAIL same_cycle_bresp: got v/resp/id %b expected 101", {v, r, i}); end
        do_read(32'h04, 1'b1, v, d, r, i, l);
        tests++; if (d !== 32'hDEADBEEF) begin fails++; $display("FAIL same_cycle_rdata: got %h expected deadbeef", d); end
        tests++; if ({v, r, i, l} !== 4'b1011) begin fails++; $display("FAIL same_cycle_rflags: got v/resp/id/last %b expected 1011", {v, r, i, l}); end
    endtask

    task automatic test_split_write();
        logic v, r, i, l; logic [31:0] d;
        // Address three cycles ahead of data.
        awvalid = 1'b1; awaddr = 32'h08; awid = 1'b0;
        step();
        awvalid = 1'b0; awaddr = 32'hFFFF_FFFF;
        tests++; if ({awready, wready, bvalid} !== 3'b010) begin fails++; $display("FAIL addr_held_ready: got %b expected 010", {awready, wready, bvalid}); end
        step(); step();
        wvalid = 1'b1; wdata = 32'h12345678;
        step();
        wvalid = 1'b0; wdata = 32'h0;
        tests++; if ({bvalid, bresp, bid} !== 3'b100) begin fails++; $display("FAIL aw_first_bresp: got %b expected 100", {bvalid, bresp, bid}); end
        bready = 1'b1; step(); bready = 1'b0;
        // Data ahead of address.
        wvalid = 1'b1; wdata = 32'h0000FFFF;
        step();
        wvalid = 1'b0; wdata = 32'h0;
        tests++; if ({awready, wready, bvalid} !== 3'b100) begin fails++; $display("FAIL data_held_ready: got %b expected 100", {awready, wready, bvalid}); end
        step();
        awvalid = 1'b1; awaddr = 32'h0C; awid = 1'b1;
        step();
        awvalid = 1'b0;
        tests++; if ({bvalid, bresp, bid} !== 3'b101) begin fails++; $display("FAIL w_first_bresp: got %b expected 101", {bvalid, bresp, bid}); end
        bready = 1'b1; step(); bready = 1'b0;
        do_read(32'h08, 1'b0, v, d, r, i, l);
        tests++; if ({r, d} !== {1'b0, 32'h12345678}) begin fails++; $display("FAIL readback_08: got resp %b data %h expected 0 12345678", r, d); end
        do_read(32'h0C, 1'b0, v, d, r, i, l);
        tests++; if ({r, d} !== {1'b0, 32'h0000FFFF}) begin fails++; $display("FAIL readback_0c: got resp %b data %h expected 0 0000ffff", r, d); end
    endtask

    task automatic test_errors();
        logic v, r, i, l; logic [31:0] d;
        do_write(32'h00, 32'hFFFFFFFF, 1'b0, v, r, i);
        tests++; if ({v, r} !== 2'b11) begin fails++; $display("FAIL write_id_reg: got v/resp %b expected 11", {v, r}); end
        do_read(32'h00, 1'b0, v, d, r, i, l);
        tests++; if ({r, d} !== {1'b0, 32'hA11E0001}) begin fails++; $display("FAIL read_id_reg: got resp %b data %h expected 0 a11e0001", r, d); end
        do_read(32'h40, 1'b1, v, d, r, i, l);
        tests++; if ({r, d, i} !== {1'b1, 32'h0, 1'b1}) begin fails++; $display("FAIL read_oor: got resp %b data %h id %b expected 1 0 1", r, d, i); end
        do_write(32'h40, 32'h55555555, 1'b0, v, r, i);
        tests++; if ({v, r} !== 2'b11) begin fails++; $display("FAIL write_oor_40: got v/resp %b expected 11", {v, r}); end
        do_write(32'h44, 32'h66666666, 1'b0, v, r, i);
        tests++; if ({v, r} !== 2'b11) begin fails++; $display("FAIL write_oor_44: got v/resp %b expected 11", {v, r}); end
        do_read(32'h04, 1'b0, v, d, r, i, l);
        tests++; if (d !== 32'hDEADBEEF) begin fails++; $display("FAIL oor_no_change_04: got %h expected deadbeef", d); end
        do_read(32'h00, 1'b0, v, d, r, i, l);
        tests++; if (d !== 32'hA11E0001) begin fails++; $display("FAIL oor_no_change_00: got %h expected a11e0001", d); end
    endtask

    task automatic test_bready_stall();
        logic v, r, i, l; logic [31:0] d;
        awvalid = 1'b1; wvalid = 1'b1; awaddr = 32'h14; wdata = 32'h0BADF00D; awid = 1'b1;
        step();
        // Next write held on the bus while the response is stalled.
        awaddr = 32'h18; wdata = 32'h00000011; awid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tests++; if ({bvalid, bresp, bid, awready, wready} !== 5'b10100)
                begin fails++; $display("FAIL stall_cycle_%0d: got bvalid/bresp/bid/awready/wready %b expected 10100", k, {bvalid, bresp, bid, awready, wready}); end
            step();
        end
        bready = 1'b1;
        step();
        bready = 1'b0;
        tests++; if ({bvalid, awready} !== 2'b01) begin fails++; $display("FAIL stall_release: got bvalid/awready %b expected 01", {bvalid, awready}); end
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        tests++; if ({bvalid, bresp, bid} !== 3'b100) begin fails++; $display("FAIL held_write_accepted: got %b expected 100", {bvalid, bresp, bid}); end
        bready = 1'b1; step(); bready = 1'b0;
        do_read(32'h14, 1'b0, v, d, r, i, l);
        tests++; if (d !== 32'h0BADF00D) begin fails++; $display("FAIL stall_readback_14: got %h expected 0badf00d", d); end
        do_read(32'h18, 1'b0, v, d, r, i, l);
        tests++; if (d !== 32'h00000011) begin fails++; $display("FAIL stall_readback_18: got %h expected 00000011", d); end
    endtask

    task automatic test_same_reg_rw();
        logic v, r, i, l; logic [31:0] d;
        awvalid = 1'b1; wvalid = 1'b1; awaddr = 32'h10; wdata = 32'hAAAA0000; awid = 1'b0;
        arvalid = 1'b1; araddr = 32'h10; arid = 1'b0;
        step();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        tests++; if ({rvalid, rresp, rdata} !== {2'b10, 32'h0}) begin fails++; $display("FAIL rw_collision_old: got rvalid %b rresp %b rdata %h expected 1 0 0", rvalid, rresp, rdata); end
        tests++; if ({bvalid, bresp} !== 2'b10) begin fails++; $display("FAIL rw_collision_bresp: got %b expected 10", {bvalid, bresp}); end
        bready = 1'b1; rready = 1'b1; step(); bready = 1'b0; rready = 1'b0;
        do_read(32'h10, 1'b0, v, d, r, i, l);
        tests++; if (d !== 32'hAAAA0000) begin fails++; $display("FAIL rw_collision_new: got %h expected aaaa0000", d); end
    endtask

    task automatic test_reset_inflight();
        logic v, r, i, l; logic [31:0] d;
        awvalid = 1'b1; wvalid = 1'b1; awaddr = 32'h04; wdata = 32'h77; awid = 1'b1;
        arvalid = 1'b1; araddr = 32'h08; arid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        tests++; if ({bvalid, rvalid} !== 2'b11) begin fails++; $display("FAIL inflight_pre: got bvalid/rvalid %b expected 11", {bvalid, rvalid}); end
        #2 reset = 1'b1;
        #1;
        tests++; if ({bvalid, rvalid} !== 2'b00) begin fails++; $display("FAIL inflight_reset: got bvalid/rvalid %b expected 00", {bvalid, rvalid}); end
        step(); step();
        reset = 1'b0;
        step();
        do_read(32'h04, 1'b0, v, d, r, i, l);
        tests++; if ({v, r, d} !== {2'b10, 32'h0}) begin fails++; $display("FAIL post_reset_read: got v %b resp %b data %h expected 1 0 0", v, r, d); end
    endtask

    initial begin
        reset = 1'b1;
        awvalid = 1'b0; awaddr = '0; awid = 1'b0;
        wvalid = 1'b0; wdata = '0; wlast = 1'b0; bready = 1'b0;
        arvalid = 1'b0; araddr = '0; arid = 1'b0; rready = 1'b0;
        #2;
        test_reset();
        test_write_same_cycle();
        test_split_write();
        test_errors();
        test_bready_stall();
        test_same_reg_rw();
        test_reset_inflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_lite_slave_regfile.md
Name: axi_lite_slave_regfile

Overview:
- AXI4-lite slave register bank that sits directly downstream of the AXI-lite interface and consumes its slave-side signal set.
- Holds NUM_REGS word-addressed registers. Register 0 is a read-only ID constant; the rest are read/write control/status registers.
- Write and read channels run independently, each with its own state machine. A single outstanding transaction per channel.

Parameters:
- DATA_SIZE, 32, data bus width in bits.
- ADDR_SIZE, 32, address bus width in bits.
- NUM_REGS, 16, number of 32-bit registers; power of two, minimum 2.
- ID_VALUE, 32'hA11E_0001, constant returned by register 0.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- awvalid  input  1  write address valid.
- awready  output  1  write address ready.
- awaddr  input  ADDR_SIZE  write byte address.
- awid  input  1  write transaction ID.
- wvalid  input  1  write data valid.
- wready  output  1  write data ready.
- wdata  input  DATA_SIZE  write data.
- wlast  input  1  ignored; every AXI-lite beat is the last beat.
- bvalid  output  1  write response valid.
- bready  input  1  write response ready.
- bresp  output  1  0 = OKAY, 1 = SLVERR.
- bid  output  1  echo of the captured awid.
- arvalid  input  1  read address valid.
- arready  output  1  read address ready.
- araddr  input  ADDR_SIZE  read byte address.
- arid  input  1  read transaction ID.
- rvalid  output  1  read data valid.
- rready  input  1  read data ready.
- rdata  output  DATA_SIZE  read data.
- rresp  output  1  0 = OKAY, 1 = SLVERR.
- rid  output  1  echo of the captured arid.
- rlast  output  1  equal to rvalid.

Behaviour:
- Reset: all outputs are 0. Registers 1..NUM_REGS-1 clear to 0. Both FSMs return to IDLE. Any in-flight transaction is dropped with no response.
- Address decode:
  - index = addr[$clog2(NUM_REGS)+1:2]; addr[1:0] is ignored.
  - Out of range when addr >= NUM_REGS*4.
- Write FSM states are W_IDLE, W_ADDR_HELD, W_DATA_HELD and W_RESP.
  - W_IDLE: awready=1 and wready=1.
    - awvalid and wvalid together: commit the write at that edge and go to W_RESP.
    - awvalid alone: latch awaddr/awid and go to W_ADDR_HELD.
    - wvalid alone: latch wdata and go to W_DATA_HELD.
  - W_ADDR_HELD: awready=0, wready=1. On wvalid, commit and go to W_RESP.
  - W_DATA_HELD: awready=1, wready=0. On awvalid, commit and go to W_RESP.
  - W_RESP: awready=0, wready=0, bvalid=1. bresp and bid stay stable until bready; on bready go to W_IDLE.
  - bvalid rises exactly 1 cycle after the completing handshake.
- Write commit rules:
  - In-range index 1..NUM_REGS-1: register <= wdata; bresp=0.
  - Index 0: no write; bresp=1.
  - Out of range: no write; bresp=1.
- Read FSM states are R_IDLE and R_RESP.
  - R_IDLE: arready=1. On arvalid, sample register[index] into rdata and set rid=arid; go to R_RESP.
  - R_RESP: arready=0, rvalid=1. rdata/rresp/rid stay stable until rready, then go to R_IDLE.
  - Read latency is 1 cycle from the ar handshake to rvalid.
  - Out-of-range read: rdata=0, rresp=1.
  - Register 0 read: rdata=ID_VALUE, rresp=0.
- Simultaneous write commit and read sample on the same register at the same edge: the read returns the old value; the new value is visible from the next read.
- The next handshake cannot be accepted in the same cycle that bready or rready is taken. Back-to-back throughput is therefore 1 transaction per 2 cycles per channel.
- Neither channel ever stalls the other.
- awvalid/arvalid held high while the slave is in a RESP state are not lost; the address is accepted after returning to IDLE.

Test Plan:
- Reset, then write awaddr=0x04, wdata=0xDEADBEEF, awid=1, with aw and w in the same cycle -> bvalid 1 cycle later, bresp=0, bid=1. Read 0x04 -> rdata=0xDEADBEEF, rresp=0, rlast=1.
- Write with aw sent 3 cycles before w (addr 0x08, data 0x12345678), then repeat with w sent before aw (addr 0x0C, data 0x0000FFFF) -> both respond OKAY; readback matches.
- Write 0x00 with 0xFFFFFFFF -> bresp=1. Read 0x00 -> 0xA11E0001. Read 0x40 -> rdata=0, rresp=1. Write 0x40 -> bresp=1, and no register changes.
- Hold bready=0 for 5 cycles after a write -> bvalid, bresp and bid stay stable; awready=0 throughout. The next write is accepted only after bready.
- In the same cycle, write 0x10 with 0xAAAA0000 and read 0x10 (previous value 0) -> rdata=0. A subsequent read returns 0xAAAA0000.
- Assert reset while in W_RESP and R_RESP -> bvalid=0 and rvalid=0 immediately. A readback of 0x04 after reset returns 0.
